// File: rtl/mips_cpu_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_store_buffer
// Description : FIFO store buffer between the MIPS data port and data memory.
//               CPU reads take the memory port first and stores drain when it
//               is free. Optional macro STORE_FORWARD_EN forwards buffered
//               bytes to matching reads; without it a matching read stalls
//               until the buffer no longer holds that word.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic [31:0]              data_address,
    input  logic [31:0]              data_writedata,
    input  logic [3:0]               data_byteenable,
    input  logic                     data_write,
    input  logic                     data_read,
    output logic [31:0]              data_readdata,
    output logic                     data_stall,
    output logic [31:0]              mem_address,
    output logic [31:0]              mem_writedata,
    output logic [3:0]               mem_byteenable,
    output logic                     mem_write,
    output logic                     mem_read,
    input  logic [31:0]              mem_readdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_be   [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_is_read;
    logic             w_block;
    logic             w_port_rd;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;
    logic [31:0]      w_rd_word;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_is_read = data_read & ~data_write;

    // w_hit[k] marks the k-th oldest live entry holding the addressed word
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((c_CW'(k) < r_count) &&
                (r_addr[r_rptr + c_AW'(k)] == data_address[31:2]))
                w_hit[k] = 1'b1;
        end
    end

`ifdef STORE_FORWARD_EN
    // Oldest-to-youngest walk so the youngest enabled byte wins
    always_comb begin
        logic [c_AW-1:0] w_idx;
        w_rd_word = mem_readdata;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + c_AW'(k);
            if (w_hit[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_idx][b])
                        w_rd_word[8*b +: 8] = r_data[w_idx][8*b +: 8];
                end
            end
        end
    end
    assign w_block = 1'b0;
`else
    assign w_rd_word = mem_readdata;
    assign w_block   = w_is_read & (|w_hit);
`endif

    assign w_port_rd = data_read & ~w_block;
    assign w_push    = clk_enable & data_write & ~w_full;
    assign w_pop     = clk_enable & ~w_empty & ~w_port_rd & ~reset;

    always_comb begin
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (w_port_rd) begin
            mem_read    = 1'b1;
            mem_address = data_address;
        end else if (w_pop) begin
            mem_write      = 1'b1;
            mem_address    = {r_addr[r_rptr], 2'b00};
            mem_writedata  = r_data[r_rptr];
            mem_byteenable = r_be[r_rptr];
        end
    end

    assign data_stall    = (data_write & w_full) | w_block;
    assign data_readdata = (w_is_read & ~w_block) ? w_rd_word : '0;
    assign empty         = w_empty;
    assign count         = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: liveness is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= data_address[31:2];
            r_data[r_wptr] <= data_writedata;
            r_be[r_wptr]   <= data_byteenable;
        end
    end

endmodule
`default_nettype wire
